// File: rtl/uart_block_packer.sv
// Packs received UART bytes into fixed-size blocks for the block FIFO.
// Short blocks are padded on line feed or idle timeout; one completed block can be held while the FIFO is full.
module uart_block_packer #(
  parameter int         BLOCK_BYTES    = 8,
  parameter logic [7:0] PAD_BYTE       = 8'h00,
  parameter bit         PAD_ON_LF      = 1'b1,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     fifo_full,
  output logic                     write_enable,
  output logic [8*BLOCK_BYTES-1:0] write_data,
  output logic                     overrun,
  output logic                     busy
);

  localparam int BW = 8 * BLOCK_BYTES;
  localparam int IW = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(BLOCK_BYTES - 1);
  localparam logic [TW-1:0] TIMER_MAX = '1;
  localparam logic [TW-1:0] EXPIRE_AT = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  logic [IW-1:0] idx_q, idx_d;
  logic [BW-1:0] asm_q, asm_d;
  logic [BW-1:0] pend_q, pend_d;
  logic          pend_valid_q, pend_valid_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          overrun_q, overrun_d;

  logic [BW-1:0] asm_wr;
  logic [BW-1:0] byte_block;
  logic [BW-1:0] idle_block;
  logic [BW-1:0] done_block;
  logic          is_lf;
  logic          byte_done;
  logic          timer_expire;
  logic          complete;
  logic          fire;

  // Per-slot views: slots below idx keep assembled data, the current slot takes the
  // incoming byte, and everything above is padding.
  for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_slot
    localparam logic [IW-1:0] SLOT = IW'(gi);
    assign asm_wr[BW-1-8*gi -: 8]     = (SLOT == idx_q) ? rx_data : asm_q[BW-1-8*gi -: 8];
    assign byte_block[BW-1-8*gi -: 8] = (SLOT < idx_q)  ? asm_q[BW-1-8*gi -: 8] :
                                        (SLOT == idx_q) ? rx_data : PAD_BYTE;
    assign idle_block[BW-1-8*gi -: 8] = (SLOT < idx_q)  ? asm_q[BW-1-8*gi -: 8] : PAD_BYTE;
  end

  assign is_lf        = PAD_ON_LF && (rx_data == 8'h0A);
  assign byte_done    = rx_valid && ((idx_q == LAST_IDX) || is_lf);
  assign timer_expire = (TIMEOUT_CYCLES > 0) && !rx_valid && (idx_q != '0) &&
                        (timer_q == EXPIRE_AT);
  assign complete     = byte_done || timer_expire;
  assign done_block   = byte_done ? byte_block : idle_block;
  assign fire         = pend_valid_q & ~fifo_full;

  always_comb begin
    idx_d        = idx_q;
    asm_d        = asm_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    timer_d      = timer_q;
    overrun_d    = overrun_q;

    if (rx_valid) begin
      asm_d   = asm_wr;
      idx_d   = idx_q + IW'(1);
      timer_d = '0;
    end else if (idx_q == '0) begin
      timer_d = '0;
    end else if (timer_q != TIMER_MAX) begin
      timer_d = timer_q + TW'(1);
    end

    if (fire) begin
      pend_valid_d = 1'b0;
    end

    if (complete) begin
      asm_d   = '0;
      idx_d   = '0;
      timer_d = '0;
      // A held block that cannot leave this cycle wins; the newcomer is lost.
      if (pend_valid_q && !fire) begin
        overrun_d = 1'b1;
      end else begin
        pend_d       = done_block;
        pend_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q        <= '0;
      asm_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      timer_q      <= '0;
      overrun_q    <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      asm_q        <= asm_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      timer_q      <= timer_d;
      overrun_q    <= overrun_d;
    end
  end

  assign write_enable = fire;
  assign write_data   = pend_q;
  assign overrun      = overrun_q;
  assign busy         = (idx_q != '0) | pend_valid_q;

endmodule

// File: tb/tb_uart_block_packer.sv
// Directed bench for uart_block_packer: expected blocks are queued when bytes are sent
// and matched against every write_enable pulse.
module tb_uart_block_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        fifo_full;
  logic        write_enable;
  logic [63:0] write_data;
  logic        overrun;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  uart_block_packer #(
    .BLOCK_BYTES    (8),
    .PAD_BYTE       (8'h00),
    .PAD_ON_LF      (1'b1),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .fifo_full    (fifo_full),
    .write_enable (write_enable),
    .write_data   (write_data),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every push must match a queued block, in order.
  always @(negedge clock) begin
    if (write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_write observed=%h expected=none", write_data);
        end
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("block", write_data, e);
        $display("write_data=%h expected=%h", write_data, e);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [63:0] blk, input int n);
    for (int i = 0; i < n; i++) send_byte(blk[63-8*i -: 8]);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      step(1);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    fifo_full = 1'b0;
    step(2);
    reset = 1'b0;
    chk("rst_we", 64'(write_enable), 64'd0);
    chk("rst_wd", write_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovr", 64'(overrun), 64'd0);

    // Full eight-byte block, one cycle latency.
    exp_q.push_back(64'h596F7572206C6970);
    send_bytes(64'h596F7572206C6970, 8);
    chk("t1_we_lat", 64'(write_enable), 64'd1);
    step(1);
    chk("t1_we_once", 64'(write_enable), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);

    // Line feed completes early with padding.
    exp_q.push_back(64'h6C696E650D0A0000);
    send_bytes(64'h6C696E650D0A0000, 6);
    chk("t2_we_lat", 64'(write_enable), 64'd1);
    step(2);
    chk("t2_busy", 64'(busy), 64'd0);

    // Backpressure holds a single block.
    fifo_full = 1'b1;
    send_bytes(64'h68616E2076617365, 8);
    step(3);
    chk("t3_we_held", 64'(write_enable), 64'd0);
    chk("t3_busy", 64'(busy), 64'd1);
    exp_q.push_back(64'h68616E2076617365);
    fifo_full = 1'b0;
    #1;
    chk("t3_we_rel", 64'(write_enable), 64'd1);
    step(1);
    chk("t3_busy_after", 64'(busy), 64'd0);

    // Second block completing while the first is held is dropped.
    fifo_full = 1'b1;
    exp_q.push_back(64'h1011121314151617);
    send_bytes(64'h1011121314151617, 8);
    chk("t4_no_ovr_yet", 64'(overrun), 64'd0);
    send_bytes(64'h18191A1B1C1D1E1F, 8);
    chk("t4_ovr", 64'(overrun), 64'd1);
    chk("t4_busy", 64'(busy), 64'd1);
    fifo_full = 1'b0;
    step(3);
    wait_drain();
    chk("t4_ovr_sticky", 64'(overrun), 64'd1);

    // Idle timeout flush: expiry on the 16th idle edge after the last byte.
    exp_q.push_back(64'h6162630000000000);
    send_bytes(64'h6162630000000000, 3);
    for (int k = 1; k <= 16; k++) begin
      step(1);
      chk($sformatf("t5_to_k%0d", k), 64'(write_enable), (k == 16) ? 64'd1 : 64'd0);
    end
    step(1);
    chk("t5_busy", 64'(busy), 64'd0);

    // A byte on the expiry cycle suppresses the flush and restarts the timer.
    send_bytes(64'h6162630000000000, 3);
    step(15);
    send_byte(8'h64);
    chk("t5_sup_we", 64'(write_enable), 64'd0);
    chk("t5_sup_busy", 64'(busy), 64'd1);
    exp_q.push_back(64'h6162636400000000);
    step(15);
    chk("t5_sup_early", 64'(write_enable), 64'd0);
    step(1);
    chk("t5_sup_flush", 64'(write_enable), 64'd1);
    step(1);

    // Reset with a held block and a partial block discards both.
    fifo_full = 1'b1;
    send_bytes(64'hA0A1A2A3A4A5A6A7, 8);
    send_bytes(64'hAAABACADAE000000, 5);
    reset = 1'b1;
    step(1);
    reset     = 1'b0;
    fifo_full = 1'b0;
    chk("t6_ovr", 64'(overrun), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_we", 64'(write_enable), 64'd0);
    exp_q.push_back(64'h596F7572206C6970);
    send_bytes(64'h596F7572206C6970, 8);
    wait_drain();
    step(2);
    chk("t6_ovr_end", 64'(overrun), 64'd0);
    chk("final_queue", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
